// File: rtl/wired_fooo_iq_age.sv
// FPU issue queue: dispatch, CDB wakeup, oldest-ready issue, response FIFO to CDB.
// Build option WIRED_FOOO_IQ_AGE_EN selects age-matrix oldest-first issue.
package wired_fooo_pkg;
  typedef logic [5:0] rob_id_t;

  typedef struct packed {
    logic [3:0] fpu_op;
    logic [2:0] rnd_mode;
    logic       op_mode;
  } fpu_di_t;

  typedef struct packed {
    fpu_di_t       di;
    logic [31:0]   pc;
    rob_id_t       wreg;
    rob_id_t [2:0] src_rid;
    logic [2:0]    src_rdy;
  } pipeline_ctrl_p_t;

  typedef struct packed {
    logic [2:0][31:0] r;
  } pipeline_data_t;

  typedef struct packed {
    logic        valid;
    rob_id_t     wid;
    logic [31:0] wdata;
    logic [4:0]  fp_excp;
    logic        excp;
    logic        need_jump;
    logic [31:0] target_addr;
    logic        uncached;
    logic        wrong_forward;
    logic [7:0]  fcc;
  } pipeline_cdb_t;

  typedef struct packed {
    logic [3:0]       fpu_op;
    logic [2:0]       rnd_mode;
    logic             op_mode;
    logic [2:0][31:0] r;
    rob_id_t          wid;
  } iq_fpu_req_t;

  typedef struct packed {
    rob_id_t     wid;
    logic [31:0] result;
    logic [4:0]  fp_excp;
  } iq_fpu_resp_t;
endpackage

module wired_fooo_iq_age
  import wired_fooo_pkg::*;
#(
  parameter int IQ_SIZE    = 4,
  parameter int CDB_CNT    = 2,
  parameter int RESP_DEPTH = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [$bits(pipeline_ctrl_p_t)-1:0]  p_ctrl_i,
  input  logic [$bits(pipeline_data_t)-1:0]    p_data_i,
  input  logic                                 p_valid_i,
  output logic                                 p_ready_o,
  input  logic [CDB_CNT*$bits(pipeline_cdb_t)-1:0] cdb_i,
  output logic [$bits(pipeline_cdb_t)-1:0]     cdb_o,
  input  logic                                 cdb_ready_i,
  output logic                                 ex_valid_o,
  input  logic                                 ex_ready_i,
  output logic [$bits(iq_fpu_req_t)-1:0]       ex_req_o,
  input  logic                                 ex_valid_i,
  output logic                                 ex_ready_o,
  input  logic [$bits(iq_fpu_resp_t)-1:0]      ex_resp_i,
  input  logic                                 flush_i
);
  localparam int CW = $bits(pipeline_cdb_t);
  localparam int IW = (IQ_SIZE > 1) ? $clog2(IQ_SIZE) : 1;
  localparam int FW = $clog2(IQ_SIZE + 1);
  localparam int RW = $clog2(RESP_DEPTH);

  pipeline_ctrl_p_t p_ctrl;
  pipeline_data_t   p_data;
  iq_fpu_resp_t     ex_resp;
  pipeline_cdb_t    cdb [CDB_CNT];
  logic [CDB_CNT-1:0] unused_cdb;
  logic             unused;

  assign p_ctrl  = pipeline_ctrl_p_t'(p_ctrl_i);
  assign p_data  = pipeline_data_t'(p_data_i);
  assign ex_resp = iq_fpu_resp_t'(ex_resp_i);
  assign unused  = ^{p_ctrl.pc, unused_cdb};

  for (genvar k = 0; k < CDB_CNT; k++) begin : g_cdb
    assign cdb[k] = pipeline_cdb_t'(cdb_i[k*CW +: CW]);
    assign unused_cdb[k] = ^{cdb[k].fp_excp, cdb[k].excp,
                             cdb[k].need_jump, cdb[k].target_addr,
                             cdb[k].uncached, cdb[k].wrong_forward,
                             cdb[k].fcc};
  end

  logic [IQ_SIZE-1:0] ent_v;
  fpu_di_t            ent_di  [IQ_SIZE];
  rob_id_t            ent_wid [IQ_SIZE];
  logic [2:0]         ent_rdy [IQ_SIZE];
  rob_id_t            ent_rid [IQ_SIZE][3];
  logic [31:0]        ent_opd [IQ_SIZE][3];

  logic [2:0]         wk      [IQ_SIZE];
  logic [31:0]        wk_d    [IQ_SIZE][3];
  logic [2:0]         d_wk;
  logic [31:0]        d_wk_d  [3];

  logic [IQ_SIZE-1:0] free_v, wr_oh, fire, sel;
  logic [IW-1:0]      sel_idx;
  logic               wr_en, exec_ready, issue;
  logic [FW-1:0]      free_cnt, free_nxt;
  iq_fpu_req_t        issue_req, ex_req_q;

  // Descending scan so the lowest-index CDB port wins on multi-match
  always_comb begin
    for (int i = 0; i < IQ_SIZE; i++) begin
      for (int s = 0; s < 3; s++) begin
        wk[i][s]   = 1'b0;
        wk_d[i][s] = '0;
        for (int k = CDB_CNT - 1; k >= 0; k--) begin
          if (cdb[k].valid && cdb[k].wid == ent_rid[i][s]) begin
            wk[i][s]   = 1'b1;
            wk_d[i][s] = cdb[k].wdata;
          end
        end
      end
    end
    for (int s = 0; s < 3; s++) begin
      d_wk[s]   = 1'b0;
      d_wk_d[s] = '0;
      for (int k = CDB_CNT - 1; k >= 0; k--) begin
        if (cdb[k].valid && cdb[k].wid == p_ctrl.src_rid[s]) begin
          d_wk[s]   = 1'b1;
          d_wk_d[s] = cdb[k].wdata;
        end
      end
    end
  end

  assign free_v     = ~ent_v;
  assign wr_oh      = free_v & (~free_v + IQ_SIZE'(1));
  assign wr_en      = p_valid_i && !flush_i;
  assign exec_ready = !ex_valid_o || ex_ready_i;
  assign issue      = (|sel) && exec_ready && !flush_i;

  always_comb begin
    for (int i = 0; i < IQ_SIZE; i++)
      fire[i] = ent_v[i] && (&ent_rdy[i]);
  end

`ifdef WIRED_FOOO_IQ_AGE_EN
  // age[i][j] set: entry j was already present when entry i was written
  logic [IQ_SIZE-1:0] age [IQ_SIZE];

  always_comb begin
    for (int i = 0; i < IQ_SIZE; i++)
      sel[i] = fire[i] && ((age[i] & fire) == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < IQ_SIZE; i++) age[i] <= '0;
    end else if (flush_i) begin
      for (int i = 0; i < IQ_SIZE; i++) age[i] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < IQ_SIZE; i++) begin
        if (wr_oh[i]) age[i] <= ent_v;
        else          age[i] <= age[i] & ~wr_oh;
      end
    end
  end
`else
  assign sel = fire & (~fire + IQ_SIZE'(1));
`endif

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < IQ_SIZE; i++)
      if (sel[i]) sel_idx = IW'(i);
  end

  always_comb begin
    issue_req          = '0;
    issue_req.fpu_op   = ent_di[sel_idx].fpu_op;
    issue_req.rnd_mode = ent_di[sel_idx].rnd_mode;
    issue_req.op_mode  = ent_di[sel_idx].op_mode;
    issue_req.wid      = ent_wid[sel_idx];
    for (int s = 0; s < 3; s++)
      issue_req.r[s] = ent_opd[sel_idx][s];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_v <= '0;
      for (int i = 0; i < IQ_SIZE; i++) begin
        ent_di[i]  <= '0;
        ent_wid[i] <= '0;
        ent_rdy[i] <= '0;
        for (int s = 0; s < 3; s++) begin
          ent_rid[i][s] <= '0;
          ent_opd[i][s] <= '0;
        end
      end
    end else if (flush_i) begin
      ent_v <= '0;
    end else begin
      for (int i = 0; i < IQ_SIZE; i++) begin
        if (wr_en && wr_oh[i]) begin
          ent_v[i]   <= 1'b1;
          ent_di[i]  <= p_ctrl.di;
          ent_wid[i] <= p_ctrl.wreg;
          for (int s = 0; s < 3; s++) begin
            ent_rdy[i][s] <= p_ctrl.src_rdy[s] | d_wk[s];
            ent_rid[i][s] <= p_ctrl.src_rid[s];
            ent_opd[i][s] <= p_ctrl.src_rdy[s] ? p_data.r[s] : d_wk_d[s];
          end
        end else begin
          if (issue && sel[i]) ent_v[i] <= 1'b0;
          for (int s = 0; s < 3; s++) begin
            if (!ent_rdy[i][s] && wk[i][s]) begin
              ent_rdy[i][s] <= 1'b1;
              ent_opd[i][s] <= wk_d[i][s];
            end
          end
        end
      end
    end
  end

  assign free_nxt = free_cnt - FW'(wr_en) + FW'(issue);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      free_cnt  <= FW'(IQ_SIZE);
      p_ready_o <= 1'b1;
    end else if (flush_i) begin
      free_cnt  <= FW'(IQ_SIZE);
      p_ready_o <= 1'b1;
    end else begin
      free_cnt  <= free_nxt;
      p_ready_o <= free_nxt != '0;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(p_valid_i && free_cnt == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_o <= 1'b0;
      ex_req_q   <= '0;
    end else if (flush_i) begin
      ex_valid_o <= 1'b0;
      ex_req_q   <= '0;
    end else if (issue) begin
      ex_valid_o <= 1'b1;
      ex_req_q   <= issue_req;
    end else if (ex_ready_i) begin
      ex_valid_o <= 1'b0;
    end
  end

  assign ex_req_o = ex_req_q;

  // Response FIFO; ex_ready_o comes from the registered count only
  iq_fpu_resp_t  fifo_mem [RESP_DEPTH];
  logic [RW-1:0] wp, rp;
  logic [RW:0]   cnt;
  logic          push, pop;
  pipeline_cdb_t cdb_q;

  assign ex_ready_o = cnt != (RW+1)'(RESP_DEPTH);
  assign push       = ex_valid_i && ex_ready_o && !flush_i;
  assign pop        = (cnt != '0) && cdb_ready_i && !flush_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else if (flush_i) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + RW'(1);
      if (pop)  rp <= rp + RW'(1);
      cnt <= cnt + (RW+1)'(push) - (RW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wp] <= ex_resp;
  end

  always_comb begin
    cdb_q         = '0;
    cdb_q.valid   = cnt != '0;
    cdb_q.wid     = fifo_mem[rp].wid;
    cdb_q.wdata   = fifo_mem[rp].result;
    cdb_q.fp_excp = fifo_mem[rp].fp_excp;
  end

  assign cdb_o = cdb_q;
endmodule

// File: tb/tb_wired_fooo_iq_age.sv
// Randomised scoreboard bench for wired_fooo_iq_age against a sequence-number model.
// Honours WIRED_FOOO_IQ_AGE_EN for the expected issue order.
module tb_wired_fooo_iq_age;
  import wired_fooo_pkg::*;

  localparam int IQ = 4;
  localparam int CN = 2;
  localparam int RD = 2;

  logic clk = 1'b0;
  logic rst;
  pipeline_ctrl_p_t p_ctrl;
  pipeline_data_t   p_data;
  logic p_valid, p_ready;
  pipeline_cdb_t [CN-1:0] cdb_in;
  pipeline_cdb_t cdb_out;
  logic cdb_ready;
  logic ex_valid_o, ex_ready_i;
  iq_fpu_req_t ex_req;
  logic ex_valid_i, ex_ready_o;
  iq_fpu_resp_t ex_resp;
  logic flush;

  wired_fooo_iq_age #(.IQ_SIZE(IQ), .CDB_CNT(CN), .RESP_DEPTH(RD)) dut (
    .clk(clk), .rst(rst),
    .p_ctrl_i(p_ctrl), .p_data_i(p_data),
    .p_valid_i(p_valid), .p_ready_o(p_ready),
    .cdb_i(cdb_in), .cdb_o(cdb_out), .cdb_ready_i(cdb_ready),
    .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i), .ex_req_o(ex_req),
    .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o), .ex_resp_i(ex_resp),
    .flush_i(flush)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             v;
    int unsigned      seq;
    logic [2:0]       rdy;
    rob_id_t [2:0]    rid;
    logic [2:0][31:0] d;
    fpu_di_t          di;
    rob_id_t          wid;
  } mslot_t;

  mslot_t       ms [IQ];
  int unsigned  seq_ctr;
  logic         m_exv, m_pready, m_exr;
  iq_fpu_req_t  m_exreq;
  iq_fpu_req_t  exp_req_q [$];
  iq_fpu_resp_t exp_cdb_q [$];
  iq_fpu_req_t  fpu_pend  [$];
  int           resp_sel;
  int           nvec = 0, nerr = 0;
  int p_disp, p_srdy, p_cdbv, p_exr, p_cdbr, p_flush;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < IQ; i++) ms[i] = '0;
    m_exv = 1'b0;
    m_exreq = '0;
    m_pready = 1'b1;
    exp_req_q.delete();
    exp_cdb_q.delete();
    fpu_pend.delete();
  endtask

  function automatic iq_fpu_resp_t fpu_calc(input iq_fpu_req_t q);
    iq_fpu_resp_t r;
    r.wid     = q.wid;
    r.result  = (q.r[0] + q.r[1]) ^ q.r[2];
    r.fp_excp = {q.op_mode, q.fpu_op};
    return r;
  endfunction

  // Model advance at each rising edge using the inputs held since the falling edge
  task automatic step();
    logic [IQ-1:0] pv;
    int pick, fr;
    logic hit;
    if (flush) begin
      for (int i = 0; i < IQ; i++) ms[i].v = 1'b0;
      m_exv = 1'b0;
      m_pready = 1'b1;
      exp_req_q.delete();
      exp_cdb_q.delete();
      fpu_pend.delete();
      return;
    end
    if (ex_valid_i && m_exr) begin
      exp_cdb_q.push_back(ex_resp);
      fpu_pend.delete(resp_sel);
    end
    if (m_exv && ex_ready_i) fpu_pend.push_back(m_exreq);
    for (int i = 0; i < IQ; i++) pv[i] = ms[i].v;
    pick = -1;
    for (int i = 0; i < IQ; i++) begin
      if (ms[i].v && (&ms[i].rdy)) begin
`ifdef WIRED_FOOO_IQ_AGE_EN
        if (pick < 0 || ms[i].seq < ms[pick].seq) pick = i;
`else
        if (pick < 0) pick = i;
`endif
      end
    end
    if (pick >= 0 && (!m_exv || ex_ready_i)) begin
      m_exv = 1'b1;
      m_exreq.fpu_op   = ms[pick].di.fpu_op;
      m_exreq.rnd_mode = ms[pick].di.rnd_mode;
      m_exreq.op_mode  = ms[pick].di.op_mode;
      m_exreq.r        = ms[pick].d;
      m_exreq.wid      = ms[pick].wid;
      exp_req_q.push_back(m_exreq);
      ms[pick].v = 1'b0;
    end else if (ex_ready_i) begin
      m_exv = 1'b0;
    end
    for (int i = 0; i < IQ; i++)
      for (int s = 0; s < 3; s++) begin
        hit = 1'b0;
        for (int k = 0; k < CN; k++)
          if (!hit && !ms[i].rdy[s] && cdb_in[k].valid &&
              cdb_in[k].wid == ms[i].rid[s]) begin
            hit = 1'b1;
            ms[i].rdy[s] = 1'b1;
            ms[i].d[s] = cdb_in[k].wdata;
          end
      end
    if (p_valid) begin
      fr = -1;
      for (int i = IQ - 1; i >= 0; i--) if (!pv[i]) fr = i;
      if (fr >= 0) begin
        ms[fr].v = 1'b1;
        ms[fr].seq = seq_ctr++;
        ms[fr].di = p_ctrl.di;
        ms[fr].wid = p_ctrl.wreg;
        for (int s = 0; s < 3; s++) begin
          ms[fr].rid[s] = p_ctrl.src_rid[s];
          ms[fr].rdy[s] = p_ctrl.src_rdy[s];
          ms[fr].d[s] = p_data.r[s];
          if (!p_ctrl.src_rdy[s]) begin
            hit = 1'b0;
            for (int k = 0; k < CN; k++)
              if (!hit && cdb_in[k].valid &&
                  cdb_in[k].wid == p_ctrl.src_rid[s]) begin
                hit = 1'b1;
                ms[fr].rdy[s] = 1'b1;
                ms[fr].d[s] = cdb_in[k].wdata;
              end
          end
        end
      end
    end
    fr = 0;
    for (int i = 0; i < IQ; i++) if (!ms[i].v) fr++;
    m_pready = fr >= 1;
  endtask

  always @(posedge clk) if (!rst) step();

  // Monitor: compare outputs and pop scoreboard entries on handshakes
  always @(negedge clk) begin
    pipeline_cdb_t ec;
    #1;
    chk("p_ready_o", 128'(p_ready), 128'(m_pready));
    chk("ex_valid_o", 128'(ex_valid_o), 128'(m_exv));
    chk("ex_ready_o", 128'(ex_ready_o), 128'(exp_cdb_q.size() < RD));
    chk("cdb_valid", 128'(cdb_out.valid), 128'(exp_cdb_q.size() != 0));
    if (m_exv && exp_req_q.size() != 0) begin
      chk("ex_req_o", 128'(ex_req), 128'(exp_req_q[0]));
      if (ex_ready_i) void'(exp_req_q.pop_front());
    end
    if (exp_cdb_q.size() != 0) begin
      ec = '0;
      ec.valid = 1'b1;
      ec.wid = exp_cdb_q[0].wid;
      ec.wdata = exp_cdb_q[0].result;
      ec.fp_excp = exp_cdb_q[0].fp_excp;
      chk("cdb_o", 128'(cdb_out), 128'(ec));
      if (cdb_ready) void'(exp_cdb_q.pop_front());
    end
  end

  task automatic idle();
    p_valid = 1'b0;
    p_ctrl = '0;
    p_data = '0;
    cdb_in = '0;
    cdb_ready = 1'b0;
    ex_ready_i = 1'b0;
    ex_valid_i = 1'b0;
    ex_resp = '0;
    flush = 1'b0;
    m_exr = 1'b0;
    resp_sel = 0;
  endtask

  function automatic logic pct(input int p);
    return $urandom_range(0, 99) < p;
  endfunction

  task automatic drive();
    @(negedge clk);
    p_valid = m_pready && pct(p_disp);
    p_ctrl = '0;
    p_ctrl.di = fpu_di_t'($urandom);
    p_ctrl.pc = $urandom;
    p_ctrl.wreg = rob_id_t'($urandom);
    for (int s = 0; s < 3; s++) begin
      p_ctrl.src_rid[s] = rob_id_t'($urandom_range(0, 7));
      p_ctrl.src_rdy[s] = pct(p_srdy);
      p_data.r[s] = $urandom;
    end
    for (int k = 0; k < CN; k++) begin
      cdb_in[k] = '0;
      cdb_in[k].valid = pct(p_cdbv);
      cdb_in[k].wid = rob_id_t'($urandom_range(0, 7));
      cdb_in[k].wdata = $urandom;
    end
    ex_ready_i = pct(p_exr);
    cdb_ready = pct(p_cdbr);
    flush = pct(p_flush);
    m_exr = exp_cdb_q.size() < RD;
    ex_valid_i = 1'b0;
    ex_resp = '0;
    if (fpu_pend.size() != 0 && m_exr && pct(60)) begin
      resp_sel = $urandom_range(0, fpu_pend.size() - 1);
      ex_valid_i = 1'b1;
      ex_resp = fpu_calc(fpu_pend[resp_sel]);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle();
    m_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic phase(input int n, input int d, input int sr, input int cv,
                       input int er, input int cr, input int fl);
    p_disp = d; p_srdy = sr; p_cdbv = cv;
    p_exr = er; p_cdbr = cr; p_flush = fl;
    repeat (n) drive();
  endtask

  initial begin
    seq_ctr = 0;
    rst = 1'b1;
    idle();
    m_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    phase(4, 0, 100, 0, 100, 100, 0);
    phase(1, 100, 100, 0, 100, 100, 0);
    phase(6, 0, 100, 0, 100, 100, 0);
    phase(8, 100, 0, 0, 100, 100, 0);
    phase(10, 0, 0, 100, 100, 100, 0);
    phase(600, 60, 50, 40, 70, 70, 0);
    phase(6, 100, 100, 0, 100, 100, 0);
    phase(12, 50, 100, 30, 0, 100, 0);
    phase(20, 60, 80, 30, 100, 0, 0);
    phase(10, 30, 80, 30, 100, 100, 0);
    phase(500, 70, 40, 40, 60, 60, 4);
    phase(8, 100, 100, 0, 100, 0, 0);
    phase(1, 0, 100, 0, 0, 0, 100);
    phase(6, 0, 100, 0, 100, 100, 0);
    phase(100, 60, 50, 40, 70, 70, 0);
    do_reset();
    phase(300, 60, 50, 40, 70, 70, 2);
    phase(100, 0, 50, 60, 100, 100, 0);
    @(negedge clk);
    idle();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
